tp2_vec_sweep: RTL and testbench

- Exhaustive input-vector sequencer. Sits directly upstream of the Guía 2 combinational exercise blocks (5 inputs a..e, 3 outputs p/x/t).
- Replaces hand-written stimulus lists: on a start request it walks every input combination from 0 to 2^N_IN-1.
- Each vector is held a programmable number of clocks, and completion is flagged.
- The top level maps vec[4..0] onto a,b,c,d,e (MSB = a).

---
 rtl/tp2_vec_sweep_pkg.sv | 22 ++
 rtl/tp2_vec_sweep_if.sv | 21 ++
 rtl/tp2_vec_sweep_misr.sv | 25 ++
 rtl/tp2_vec_sweep.sv | 105 ++++++++++
 tb/tb_tp2_vec_sweep.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tp2_vec_sweep_pkg.sv
// Shared types and constants for the exhaustive vector sweeper and its response MISR.
package tp2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    localparam int          HOLD_W    = 8;

    // One MISR step: shift with x^16+x^12+x^5+1 feedback, then fold the response into the low bits.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [2:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000);
        t[2:0] = t[2:0] ^ r;
        return t;
    endfunction

endpackage

// File: rtl/tp2_vec_sweep_if.sv
// Sweep control/status bundle: master drives start/pause/resp_i, slave returns vector and status.
interface tp2_vec_sweep_if #(parameter int N_IN = 5);
    logic            start;
    logic            pause;
    logic [N_IN-1:0] vec;
    logic            vec_valid;
    logic            busy;
    logic            done;
    logic [2:0]      resp_i;
    logic [15:0]     signature;

    modport master (
        output start, pause, resp_i,
        input  vec, vec_valid, busy, done, signature
    );

    modport slave (
        input  start, pause, resp_i,
        output vec, vec_valid, busy, done, signature
    );
endinterface

// File: rtl/tp2_vec_sweep_misr.sv
// 16-bit MISR compressing the 3-bit UUT response; seed load has priority over update.
// Latency: signature reflects a response one clock after the enabled cycle.
// Backpressure: none; the caller gates en.
module tp2_misr
    import tp2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic        en,
    input  logic [2:0]  resp,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= 16'h0000;
        end else if (seed_load) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= misr_step(sig, resp);
        end
    end

endmodule

// File: rtl/tp2_vec_sweep.sv
// Exhaustive input-vector sequencer: walks 0..2^N_IN-1, each vector held HOLD_CYC clocks (MISR under SWEEP_SIG_EN).
// Latency: vec_valid rises one clock after start; done rises one clock after the last vector's final hold cycle.
// Backpressure: pause (level) freezes vector, hold counter and signature; start is ignored while running.
module tp2_vec_sweep
    import tp2_pkg::*;
#(
    parameter int N_IN     = 5,
    parameter int HOLD_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    tp2_vec_sweep_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;
    localparam logic [N_IN-1:0]   VEC_ONE   = 1;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;

    state_t            state;
    logic [N_IN-1:0]   vec_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              vec_valid_q;
    logic              busy_q;
    logic              done_q;

    logic start_acc;
    logic vec_last_hold;

    assign start_acc     = bus.start && (state != ST_RUN);
    assign vec_last_hold = (state == ST_RUN) && !bus.pause && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            vec_q       <= '0;
            hold_cnt    <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state       <= ST_RUN;
                        vec_q       <= '0;
                        hold_cnt    <= '0;
                        vec_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.pause) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            // Last vector leaves vec at all-ones; no wrap back to 0.
                            if (vec_q == VEC_LAST) begin
                                state       <= ST_DONE;
                                vec_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                vec_q <= vec_q + VEC_ONE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    vec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec       = vec_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef SWEEP_SIG_EN
    logic [15:0] sig;

    tp2_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (start_acc),
        .en        (vec_last_hold),
        .resp      (bus.resp_i),
        .sig       (sig)
    );

    assign bus.signature = sig;
`else
    logic unused_sig_inputs;
    assign unused_sig_inputs = ^{bus.resp_i, start_acc, vec_last_hold};
    assign bus.signature     = 16'h0000;
`endif

endmodule

// File: tb/tb_tp2_vec_sweep.sv
// Directed bench for tp2_vec_sweep: HOLD_CYC=1 and HOLD_CYC=3 instances, pause, restart, reset and MISR cases.
module tb_tp2_vec_sweep;

    logic clk = 1'b0;
    logic rst;
    bit   flip_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tp2_vec_sweep_if #(.N_IN(5)) if1 ();
    tp2_vec_sweep_if #(.N_IN(5)) if3 ();

    tp2_vec_sweep #(.N_IN(5), .HOLD_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    tp2_vec_sweep #(.N_IN(5), .HOLD_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Stand-in for the tp2ej10 exercise block: vec[4..0] = a..e, response {p,x,t}.
    function automatic logic [2:0] ej10(input logic [4:0] v);
        logic a, b, c, d, e, p, x, t;
        {a, b, c, d, e} = v;
        p = (a & b) | (~c & d);
        x = a ^ b ^ c ^ d ^ e;
        t = ~(b | e) | (a & c);
        return {p, x, t};
    endfunction

    assign if1.resp_i = ej10(if1.vec) ^ ((flip_en && if1.vec == 5'd20) ? 3'b010 : 3'b000);
    assign if3.resp_i = ej10(if3.vec);

    function automatic logic [15:0] model_sig(input bit flip);
        logic [15:0] s;
        logic [15:0] t;
        logic [2:0]  r;
        s = 16'hFFFF;
        for (int v = 0; v < 32; v++) begin
            r = ej10(5'(v));
            if (flip && v == 20) r = r ^ 3'b010;
            t = {s[14:0], 1'b0};
            if (s[15]) t = t ^ 16'h1021;
            t[2:0] = t[2:0] ^ r;
            s = t;
        end
        return s;
    endfunction

    function automatic logic [7:0] pk(input logic [4:0] v, input logic vld, input logic bsy, input logic dn);
        return {v, vld, bsy, dn};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         sel3;
        int         cyc;
        logic [4:0] vec;
        logic       vld;
        logic       bsy;
        logic       dn;
    } chk_t;

    chk_t tbl[$];

    initial begin
        logic [7:0]  act;
        logic [15:0] exp_sig;

        tbl.push_back('{1'b0,  1, 5'd0,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32, 5'd31, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 33, 5'd31, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 50, 5'd31, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1,  1, 5'd0,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1,  3, 5'd0,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1,  4, 5'd1,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 15, 5'd4,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 16, 5'd5,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 18, 5'd5,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 19, 5'd6,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 96, 5'd31, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 97, 5'd31, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1,100, 5'd31, 1'b0, 1'b0, 1'b1});

        rst = 1'b1;
        if1.start = 1'b0; if1.pause = 1'b0;
        if3.start = 1'b0; if3.pause = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset1", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), 8'h00);
        chk("reset3", pk(if3.vec, if3.vec_valid, if3.busy, if3.done), 8'h00);
        chk("reset_sig", if1.signature, 16'h0000);

        // Both instances start together; cycle 1 is the first after the start edge.
        if1.start = 1'b1; if3.start = 1'b1;
        tick();
        if1.start = 1'b0; if3.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            foreach (tbl[i]) begin
                if (tbl[i].cyc == c) begin
                    act = tbl[i].sel3 ? pk(if3.vec, if3.vec_valid, if3.busy, if3.done)
                                      : pk(if1.vec, if1.vec_valid, if1.busy, if1.done);
                    chk($sformatf("tbl%0d_c%0d", i, c), act,
                        pk(tbl[i].vec, tbl[i].vld, tbl[i].bsy, tbl[i].dn));
                end
            end
            if (c <= 32) chk($sformatf("seq1_c%0d", c), {if1.vec, if1.vec_valid}, {5'(c - 1), 1'b1});
            if (c < 100) tick();
        end
`ifdef SWEEP_SIG_EN
        exp_sig = model_sig(1'b0);
`else
        exp_sig = 16'h0000;
`endif
        chk("sig1", if1.signature, exp_sig);
        chk("sig3", if3.signature, exp_sig);

        // Restart from DONE, then pause 4 cycles while vec=10.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("restart_c1", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd0, 1'b1, 1'b1, 1'b0));
        repeat (10) tick();
        chk("pre_pause", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd10, 1'b1, 1'b1, 1'b0));
        if1.pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("paused%0d", k), {if1.vec, if1.vec_valid}, {5'd10, 1'b1});
        end
        if1.pause = 1'b0;
        tick();
        chk("post_pause", if1.vec, 5'd11);
        repeat (20) tick();
        chk("pause_c36", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd31, 1'b1, 1'b1, 1'b0));
        tick();
        chk("pause_c37", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd31, 1'b0, 1'b0, 1'b1));
        chk("pause_sig", if1.signature, exp_sig);

        // Start while running at vec=8 is ignored; response bit flipped at vector 20.
        flip_en = 1'b1;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (8) tick();
        chk("busy_c9", if1.vec, 5'd8);
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("ign_c10", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd9, 1'b1, 1'b1, 1'b0));
        tick();
        chk("ign_c11", if1.vec, 5'd10);
        repeat (22) tick();
        chk("ign_c33", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd31, 1'b0, 1'b0, 1'b1));
`ifdef SWEEP_SIG_EN
        chk("flip_sig", if1.signature, model_sig(1'b1));
        chk("flip_differs", {15'd0, if1.signature != model_sig(1'b0)}, 16'd1);
`else
        chk("flip_sig_off", if1.signature, 16'h0000);
`endif
        flip_en = 1'b0;

        // Reset mid-sweep at vec=17.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (17) tick();
        chk("pre_rst", {if1.vec, if1.vec_valid}, {5'd17, 1'b1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid1", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), 8'h00);
        chk("rst_mid3", pk(if3.vec, if3.vec_valid, if3.busy, if3.done), 8'h00);
        chk("rst_mid_sig", if1.signature, 16'h0000);

        // start and rst together: reset wins.
        rst = 1'b1; if1.start = 1'b1;
        tick();
        rst = 1'b0; if1.start = 1'b0;
        chk("rst_wins", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), 8'h00);
        tick();
        chk("rst_wins_hold", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), 8'h00);

        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("post_rst_c1", pk(if1.vec, if1.vec_valid, if1.busy, if1.done), pk(5'd0, 1'b1, 1'b1, 1'b0));
        repeat (3) tick();
        chk("post_rst_c4", if1.vec, 5'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
